// File: rtl/gray_lbp_host_pkg.sv
// Shared constants, state encoding and address helpers for the gray/LBP image host.
package gray_lbp_host_pkg;

    localparam int unsigned IMG_DIM_DEF = 128;
    localparam int unsigned ADDR_W_DEF  = 14;
    localparam int unsigned PIX_CNT     = IMG_DIM_DEF * IMG_DIM_DEF;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SERVE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // True when a raster address lies on the outer ring of a dim x dim image.
    function automatic logic is_border(input int unsigned addr, input int unsigned dim);
        int unsigned row;
        int unsigned col;
        row = addr / dim;
        col = addr % dim;
        return (row == 0) || (row == dim - 1) || (col == 0) || (col == dim - 1);
    endfunction

endpackage

// File: rtl/gray_lbp_host_if.sv
// Loader, gray-read, LBP-write and result-readback signals between the LBP engine and the host.
interface gray_lbp_host_if
    import gray_lbp_host_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              img_valid;
    logic [7:0]        img_data;
    logic              gray_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [7:0]        gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              finish;
    logic [ADDR_W-1:0] res_addr;
    logic [7:0]        res_data;
    logic              done;
    logic [ADDR_W-1:0] wr_cnt;
    logic              err;

    modport master (
        output img_valid, img_data, gray_req, gray_addr,
               lbp_valid, lbp_addr, lbp_data, finish, res_addr,
        input  gray_ready, gray_data, res_data, done, wr_cnt, err
    );

    modport slave (
        input  img_valid, img_data, gray_req, gray_addr,
               lbp_valid, lbp_addr, lbp_data, finish, res_addr,
        output gray_ready, gray_data, res_data, done, wr_cnt, err
    );
endinterface

// File: rtl/lbp_host_ram.sv
// 8-bit x 2^ADDR_W storage with one synchronous write port and one asynchronous read port.
module lbp_host_ram #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/gray_lbp_host.sv
// Gray image host for an LBP engine: loads the image, serves gray reads, collects LBP results.
// Define GRAY_LBP_HOST_CHK_EN to build the sticky protocol checker driving err.
module gray_lbp_host
    import gray_lbp_host_pkg::*;
#(
    parameter int unsigned IMG_DIM = IMG_DIM_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    gray_lbp_host_if.slave bus
);
    localparam int unsigned       N_PIX    = IMG_DIM * IMG_DIM;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(N_PIX - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ld_ptr, ld_ptr_nxt;
    logic [ADDR_W-1:0] wr_cnt_r, wr_cnt_nxt;
    logic              gray_ready_r, gray_ready_nxt;
    logic              done_r, done_nxt;
    logic              load_we_c;
    logic              lbp_we_c;
    logic [ADDR_W-1:0] lbp_waddr_c;
    logic [7:0]        lbp_wdata_c;
    logic [7:0]        gray_rd_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            ld_ptr       <= '0;
            wr_cnt_r     <= '0;
            gray_ready_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state        <= state_nxt;
            ld_ptr       <= ld_ptr_nxt;
            wr_cnt_r     <= wr_cnt_nxt;
            gray_ready_r <= gray_ready_nxt;
            done_r       <= done_nxt;
        end
    end

    // Next-state and write-enable decode; inputs not legal in the current state fall through.
    always_comb begin
        state_nxt      = state;
        ld_ptr_nxt     = ld_ptr;
        wr_cnt_nxt     = wr_cnt_r;
        gray_ready_nxt = gray_ready_r;
        done_nxt       = done_r;
        load_we_c      = 1'b0;
        lbp_we_c       = 1'b0;
        case (state)
            ST_IDLE, ST_LOAD: begin
                if (bus.img_valid) begin
                    load_we_c = 1'b1;
                    if (ld_ptr == LAST_PTR) begin
                        state_nxt      = ST_SERVE;
                        gray_ready_nxt = 1'b1;
                    end else begin
                        state_nxt  = ST_LOAD;
                        ld_ptr_nxt = ld_ptr + ADDR_W'(1);
                    end
                end
            end
            ST_SERVE: begin
                if (bus.lbp_valid) begin
                    lbp_we_c   = 1'b1;
                    wr_cnt_nxt = wr_cnt_r + ADDR_W'(1);
                end
                if (bus.finish) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Loading clears the result slot at the same address as each new gray pixel.
    assign lbp_waddr_c = load_we_c ? ld_ptr : bus.lbp_addr;
    assign lbp_wdata_c = load_we_c ? 8'h00 : bus.lbp_data;

    lbp_host_ram #(.ADDR_W(ADDR_W)) u_gray_mem (
        .clk   (clk),
        .we    (load_we_c),
        .waddr (ld_ptr),
        .wdata (bus.img_data),
        .raddr (bus.gray_addr),
        .rdata (gray_rd_c)
    );

    lbp_host_ram #(.ADDR_W(ADDR_W)) u_lbp_mem (
        .clk   (clk),
        .we    (load_we_c | lbp_we_c),
        .waddr (lbp_waddr_c),
        .wdata (lbp_wdata_c),
        .raddr (bus.res_addr),
        .rdata (bus.res_data)
    );

    assign bus.gray_data  = bus.gray_req ? gray_rd_c : 8'h00;
    assign bus.gray_ready = gray_ready_r;
    assign bus.done       = done_r;
    assign bus.wr_cnt     = wr_cnt_r;

`ifdef GRAY_LBP_HOST_CHK_EN
    logic err_r;
    logic err_hit_c;

    // Out-of-state strobes, early gray reads and border result writes all latch err.
    always_comb begin
        err_hit_c = 1'b0;
        if (bus.img_valid && ((state == ST_SERVE) || (state == ST_DONE))) err_hit_c = 1'b1;
        if (bus.lbp_valid && (state != ST_SERVE))                         err_hit_c = 1'b1;
        if (bus.finish && (state != ST_SERVE))                            err_hit_c = 1'b1;
        if (bus.gray_req && !gray_ready_r)                                err_hit_c = 1'b1;
        if (lbp_we_c && is_border(32'(bus.lbp_addr), IMG_DIM))            err_hit_c = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (err_hit_c) begin
            err_r <= 1'b1;
        end
    end

    assign bus.err = err_r;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_lbp_host.sv
// Self-checking bench for gray_lbp_host: randomized images and writes against an array-based model.
module tb_gray_lbp_host;
    import gray_lbp_host_pkg::*;

    localparam int DIM  = 128;
    localparam int AW   = 14;
    localparam int NPIX = PIX_CNT;

`ifdef GRAY_LBP_HOST_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    gray_lbp_host_if #(.ADDR_W(AW)) bus ();

    gray_lbp_host #(.IMG_DIM(DIM), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] gray_m [NPIX];
    logic [7:0] lbp_m  [NPIX];
    int         wr_m;
    bit         err_m;
    int         checks = 0;
    int         passes = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.img_valid = 1'b0;
        bus.img_data  = 8'h00;
        bus.gray_req  = 1'b0;
        bus.gray_addr = '0;
        bus.lbp_valid = 1'b0;
        bus.lbp_addr  = '0;
        bus.lbp_data  = 8'h00;
        bus.finish    = 1'b0;
        bus.res_addr  = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        wr_m  = 0;
        err_m = 1'b0;
    endtask

    function automatic bit border(input int a);
        return (a / DIM == 0) || (a / DIM == DIM - 1) || (a % DIM == 0) || (a % DIM == DIM - 1);
    endfunction

    // Neighbour >= centre sets the bit; bits run row-major over the 3x3 window, centre skipped.
    function automatic logic [7:0] lbp_code(input int r, input int c);
        logic [7:0] code = 8'h00;
        logic [7:0] ctr  = gray_m[r * DIM + c];
        int         k    = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0)) begin
                    if (gray_m[(r + dr) * DIM + c + dc] >= ctr) code[k] = 1'b1;
                    k++;
                end
            end
        end
        return code;
    endfunction

    // Streams gray_m[0..n-1]; gray_ready must stay low until the final image pixel is taken.
    task automatic load_image(input int n, input bit chk_each);
        for (int i = 0; i < n; i++) begin
            bus.img_valid = 1'b1;
            bus.img_data  = gray_m[i];
            step();
            lbp_m[i] = 8'h00;
            if (chk_each || i >= n - 2) begin
                checks++;
                if (bus.gray_ready !== (i == NPIX - 1))
                    $display("FAIL gray_ready pixel %0d got %b want %b", i + 1, bus.gray_ready, (i == NPIX - 1));
                else passes++;
            end
        end
        bus.img_valid = 1'b0;
    endtask

    task automatic sweep_results(input string tag);
        for (int a = 0; a < NPIX; a++) begin
            bus.res_addr = AW'(a);
            #2;
            checks++;
            if (bus.res_data !== lbp_m[a])
                $display("FAIL %s res_data[%0d] got %02h want %02h", tag, a, bus.res_data, lbp_m[a]);
            else passes++;
        end
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 4;
        if (bus.gray_ready !== 1'b0) $display("FAIL reset gray_ready got %b want 0", bus.gray_ready); else passes++;
        if (bus.done !== 1'b0)       $display("FAIL reset done got %b want 0", bus.done); else passes++;
        if (bus.wr_cnt !== '0)       $display("FAIL reset wr_cnt got %0d want 0", bus.wr_cnt); else passes++;
        if (bus.err !== 1'b0)        $display("FAIL reset err got %b want 0", bus.err); else passes++;
    endtask

    task automatic test_reset_abort();
        apply_reset();
        for (int i = 0; i < 8000; i++) gray_m[i] = 8'($urandom);
        load_image(8000, 1'b1);
        // Read, write and finish all arrive while the image is still loading.
        bus.gray_req  = 1'b1;
        bus.gray_addr = AW'(5);
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = AW'(3);
        bus.lbp_data  = 8'h77;
        bus.finish    = 1'b1;
        #1;
        checks++;
        if (bus.gray_data !== gray_m[5]) $display("FAIL early_gray_data got %02h want %02h", bus.gray_data, gray_m[5]);
        else passes++;
        step();
        clear_inputs();
        if (CHK_EN) err_m = 1'b1;
        bus.res_addr = AW'(3);
        #1;
        checks += 4;
        if (bus.res_data !== 8'h00) $display("FAIL load_lbp_ignored got %02h want 00", bus.res_data); else passes++;
        if (bus.err !== err_m)      $display("FAIL load_err got %b want %b", bus.err, err_m); else passes++;
        if (bus.done !== 1'b0)      $display("FAIL load_finish_done got %b want 0", bus.done); else passes++;
        if (bus.wr_cnt !== '0)      $display("FAIL load_wr_cnt got %0d want 0", bus.wr_cnt); else passes++;
        apply_reset();
        checks += 2;
        if (bus.gray_ready !== 1'b0) $display("FAIL abort gray_ready got %b want 0", bus.gray_ready); else passes++;
        if (bus.err !== 1'b0)        $display("FAIL abort err got %b want 0", bus.err); else passes++;
        for (int i = 0; i < NPIX; i++) gray_m[i] = 8'(i);
        load_image(NPIX, 1'b1);
        checks++;
        if (bus.wr_cnt !== '0) $display("FAIL reload wr_cnt got %0d want 0", bus.wr_cnt); else passes++;
        sweep_results("reload_zero");
    endtask

    task automatic test_gray_read();
        int a;
        bus.gray_req  = 1'b1;
        bus.gray_addr = AW'(129);
        #1;
        checks++;
        if (bus.gray_data !== 8'h81) $display("FAIL gray_129 got %02h want 81", bus.gray_data); else passes++;
        bus.gray_req  = 1'b0;
        bus.gray_addr = AW'(5);
        #1;
        checks++;
        if (bus.gray_data !== 8'h00) $display("FAIL gray_noreq got %02h want 00", bus.gray_data); else passes++;
        for (int k = 0; k < 48; k++) begin
            step();
            a = int'($urandom_range(0, NPIX - 1));
            bus.gray_req  = 1'b1;
            bus.gray_addr = AW'(a);
            #1;
            checks++;
            if (bus.gray_data !== gray_m[a]) $display("FAIL gray_rand[%0d] got %02h want %02h", a, bus.gray_data, gray_m[a]);
            else passes++;
        end
        bus.gray_req = 1'b0;
        step();
        bus.img_valid = 1'b1;
        bus.img_data  = 8'hEE;
        step();
        bus.img_valid = 1'b0;
        if (CHK_EN) err_m = 1'b1;
        bus.gray_req = 1'b1;
        checks += 4;
        bus.gray_addr = AW'(0);
        #1;
        if (bus.gray_data !== gray_m[0]) $display("FAIL serve_img_first got %02h want %02h", bus.gray_data, gray_m[0]); else passes++;
        bus.gray_addr = AW'(NPIX - 1);
        #1;
        if (bus.gray_data !== gray_m[NPIX - 1]) $display("FAIL serve_img_last got %02h want %02h", bus.gray_data, gray_m[NPIX - 1]); else passes++;
        if (bus.gray_ready !== 1'b1) $display("FAIL serve_gray_ready got %b want 1", bus.gray_ready); else passes++;
        if (bus.err !== err_m)       $display("FAIL serve_img_err got %b want %b", bus.err, err_m); else passes++;
        bus.gray_req = 1'b0;
        step();
    endtask

    task automatic test_lbp_write();
        logic [AW-1:0] pool [6];
        logic [7:0]    d;
        int            a;
        d = 8'($urandom_range(1, 255));
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = AW'(0);
        bus.lbp_data  = d;
        step();
        clear_inputs();
        lbp_m[0] = d;
        wr_m++;
        if (CHK_EN) err_m = 1'b1;
        #1;
        checks += 3;
        if (bus.res_data !== d)        $display("FAIL border_write got %02h want %02h", bus.res_data, d); else passes++;
        if (bus.wr_cnt !== AW'(wr_m))  $display("FAIL border_wr_cnt got %0d want %0d", bus.wr_cnt, wr_m); else passes++;
        if (bus.err !== err_m)         $display("FAIL border_err got %b want %b", bus.err, err_m); else passes++;
        for (int i = 0; i < 6; i++) pool[i] = AW'($urandom);
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                a = ($urandom_range(0, 1) == 1) ? int'(pool[$urandom_range(0, 5)]) : int'($urandom_range(0, NPIX - 1));
                d = 8'($urandom);
                bus.lbp_valid = 1'b1;
                bus.lbp_addr  = AW'(a);
                bus.lbp_data  = d;
                step();
                clear_inputs();
                lbp_m[a] = d;
                wr_m++;
                if (CHK_EN && border(a)) err_m = 1'b1;
                bus.res_addr = AW'(a);
                #1;
                checks++;
                if (bus.res_data !== lbp_m[a]) $display("FAIL rand_write[%0d] got %02h want %02h", a, bus.res_data, lbp_m[a]);
                else passes++;
            end else begin
                step();
            end
            checks++;
            if (bus.wr_cnt !== AW'(wr_m)) $display("FAIL rand_wr_cnt got %0d want %0d", bus.wr_cnt, wr_m); else passes++;
        end
        checks += 2;
        if (bus.err !== err_m)  $display("FAIL rand_err got %b want %b", bus.err, err_m); else passes++;
        if (bus.done !== 1'b0)  $display("FAIL pre_finish_done got %b want 0", bus.done); else passes++;
        // Final write and finish land in the same cycle.
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = AW'(16'h3F7E);
        bus.lbp_data  = 8'hA5;
        bus.finish    = 1'b1;
        step();
        clear_inputs();
        lbp_m[16'h3F7E] = 8'hA5;
        wr_m++;
        bus.res_addr = AW'(16'h3F7E);
        #1;
        checks += 3;
        if (bus.res_data !== 8'hA5)   $display("FAIL fin_write got %02h want a5", bus.res_data); else passes++;
        if (bus.wr_cnt !== AW'(wr_m)) $display("FAIL fin_wr_cnt got %0d want %0d", bus.wr_cnt, wr_m); else passes++;
        if (bus.done !== 1'b1)        $display("FAIL fin_done got %b want 1", bus.done); else passes++;
        // Strobes arriving after completion must leave everything untouched.
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = AW'(16'h0100);
        bus.lbp_data  = 8'h5A;
        bus.finish    = 1'b1;
        bus.img_valid = 1'b1;
        bus.img_data  = 8'h33;
        step();
        clear_inputs();
        if (CHK_EN) err_m = 1'b1;
        bus.res_addr  = AW'(16'h0100);
        bus.gray_req  = 1'b1;
        bus.gray_addr = AW'(NPIX - 1);
        #1;
        checks += 6;
        if (bus.res_data !== lbp_m[256])        $display("FAIL done_write got %02h want %02h", bus.res_data, lbp_m[256]); else passes++;
        if (bus.wr_cnt !== AW'(wr_m))           $display("FAIL done_wr_cnt got %0d want %0d", bus.wr_cnt, wr_m); else passes++;
        if (bus.done !== 1'b1)                  $display("FAIL done_hold got %b want 1", bus.done); else passes++;
        if (bus.gray_ready !== 1'b1)            $display("FAIL done_gray_ready got %b want 1", bus.gray_ready); else passes++;
        if (bus.err !== err_m)                  $display("FAIL done_err got %b want %b", bus.err, err_m); else passes++;
        if (bus.gray_data !== gray_m[NPIX - 1]) $display("FAIL done_img got %02h want %02h", bus.gray_data, gray_m[NPIX - 1]); else passes++;
        clear_inputs();
        step();
        sweep_results("serve_writes");
    endtask

    task automatic test_checkerboard();
        logic [7:0] ca;
        logic [7:0] cb;
        int         cs;
        int         idx;
        apply_reset();
        checks += 3;
        if (bus.done !== 1'b0)       $display("FAIL cb_reset_done got %b want 0", bus.done); else passes++;
        if (bus.gray_ready !== 1'b0) $display("FAIL cb_reset_gray_ready got %b want 0", bus.gray_ready); else passes++;
        if (bus.wr_cnt !== '0)       $display("FAIL cb_reset_wr_cnt got %0d want 0", bus.wr_cnt); else passes++;
        ca = 8'($urandom);
        do cb = 8'($urandom); while (cb == ca);
        cs = 1 << $urandom_range(0, 3);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                gray_m[r * DIM + c] = (((r / cs) + (c / cs)) % 2 == 1) ? ca : cb;
        load_image(NPIX, 1'b0);
        for (int r = 1; r < DIM - 1; r++) begin
            for (int c = 1; c < DIM - 1; c++) begin
                idx = r * DIM + c;
                lbp_m[idx]    = lbp_code(r, c);
                bus.gray_req  = 1'b1;
                bus.gray_addr = AW'(idx);
                bus.lbp_valid = 1'b1;
                bus.lbp_addr  = AW'(idx);
                bus.lbp_data  = lbp_m[idx];
                #1;
                checks++;
                if (bus.gray_data !== gray_m[idx]) $display("FAIL cb_gray[%0d] got %02h want %02h", idx, bus.gray_data, gray_m[idx]);
                else passes++;
                step();
                wr_m++;
            end
        end
        clear_inputs();
        bus.finish = 1'b1;
        step();
        bus.finish = 1'b0;
        checks += 4;
        if (bus.done !== 1'b1)        $display("FAIL cb_done got %b want 1", bus.done); else passes++;
        if (bus.wr_cnt !== AW'(15876)) $display("FAIL cb_wr_cnt got %0d want 15876", bus.wr_cnt); else passes++;
        if (wr_m != 15876)            $display("FAIL cb_write_count got %0d want 15876", wr_m); else passes++;
        if (bus.err !== err_m)        $display("FAIL cb_err got %b want %b", bus.err, err_m); else passes++;
        sweep_results("checkerboard");
    endtask

    initial begin
        test_reset();
        test_reset_abort();
        test_gray_read();
        test_lbp_write();
        test_checkerboard();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
